// File: rtl/cc_speed_timer.sv
// Speed time-base counter: feeds the speed comparator and emits a one-cycle tick on each match.
// Optional `CC_SPEEDTIMER_BOOST_EN adds a boost input that halves the time constant loaded at a wrap.
module cc_speed_timer #(
  parameter int unsigned           DATAWIDTH  = 23,
  parameter int unsigned           LEVELWIDTH = 2,
  parameter int unsigned           MAX_LEVEL  = 3,
  parameter logic [DATAWIDTH-1:0]  TIME_BASE  = DATAWIDTH'(4000000),
  parameter logic [DATAWIDTH-1:0]  TIME_STEP  = DATAWIDTH'(1000000)
) (
  input  logic                  CC_SPEEDTIMER_CLOCK_50,
  input  logic                  CC_SPEEDTIMER_RESET_InHigh,
  input  logic                  CC_SPEEDTIMER_enable_InHigh,
  input  logic                  CC_SPEEDTIMER_speedUp_InLow,
  input  logic                  CC_SPEEDTIMER_speedDown_InLow,
`ifdef CC_SPEEDTIMER_BOOST_EN
  input  logic                  CC_SPEEDTIMER_boost_InHigh,
`endif
  input  logic                  CC_SPEEDTIMER_T0_InLow,
  output logic [DATAWIDTH-1:0]  CC_SPEEDTIMER_data_OutBUS,
  output logic [DATAWIDTH-1:0]  CC_SPEEDTIMER_timeCte_OutBUS,
  output logic [LEVELWIDTH-1:0] CC_SPEEDTIMER_level_OutBUS,
  output logic                  CC_SPEEDTIMER_tick_OutHigh
);

  typedef enum logic [1:0] {StIdle, StRun, StPause} state_e;
  typedef enum logic [1:0] {ReqNone, ReqUp, ReqDown} req_e;

  state_e                state_q;
  req_e                  pend_q, pend_d, req_now;
  logic [DATAWIDTH-1:0]  count_q, tc_q, tc_d, tc_base;
  logic [LEVELWIDTH-1:0] level_q, level_d;
  logic                  tick_q, wrap, boost;

`ifdef CC_SPEEDTIMER_BOOST_EN
  assign boost = CC_SPEEDTIMER_boost_InHigh;
`else
  assign boost = 1'b0;
`endif

  always_comb begin
    req_now = ReqNone;
    if (!CC_SPEEDTIMER_speedUp_InLow && CC_SPEEDTIMER_speedDown_InLow) begin
      req_now = ReqUp;
    end else if (CC_SPEEDTIMER_speedUp_InLow && !CC_SPEEDTIMER_speedDown_InLow) begin
      req_now = ReqDown;
    end

    // The count > constant guard catches a missed match so the count never runs away.
    wrap = (state_q != StIdle) && CC_SPEEDTIMER_enable_InHigh &&
           (!CC_SPEEDTIMER_T0_InLow || (count_q > tc_q));

    // A wrap consumes the pending request; a request on the wrap edge itself is kept.
    if (wrap) begin
      pend_d = req_now;
    end else if (req_now != ReqNone) begin
      pend_d = req_now;
    end else begin
      pend_d = pend_q;
    end

    level_d = level_q;
    if (pend_q == ReqUp && level_q < LEVELWIDTH'(MAX_LEVEL)) begin
      level_d = level_q + 1'b1;
    end else if (pend_q == ReqDown && level_q != '0) begin
      level_d = level_q - 1'b1;
    end

    tc_base = TIME_BASE - DATAWIDTH'(level_d) * TIME_STEP;
    tc_d    = boost ? (tc_base >> 1) : tc_base;
  end

  always_ff @(posedge CC_SPEEDTIMER_CLOCK_50 or posedge CC_SPEEDTIMER_RESET_InHigh) begin
    if (CC_SPEEDTIMER_RESET_InHigh) begin
      state_q <= StIdle;
      pend_q  <= ReqNone;
      count_q <= '0;
      tc_q    <= TIME_BASE;
      level_q <= '0;
      tick_q  <= 1'b0;
    end else begin
      pend_q <= pend_d;
      tick_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          count_q <= '0;
          if (CC_SPEEDTIMER_enable_InHigh) state_q <= StRun;
        end
        StRun, StPause: begin
          if (CC_SPEEDTIMER_enable_InHigh) begin
            state_q <= StRun;
            if (wrap) begin
              count_q <= '0;
              tick_q  <= 1'b1;
              level_q <= level_d;
              tc_q    <= tc_d;
            end else begin
              count_q <= count_q + 1'b1;
            end
          end else begin
            state_q <= StPause;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign CC_SPEEDTIMER_data_OutBUS    = count_q;
  assign CC_SPEEDTIMER_timeCte_OutBUS = tc_q;
  assign CC_SPEEDTIMER_level_OutBUS   = level_q;
  assign CC_SPEEDTIMER_tick_OutHigh   = tick_q;

endmodule

// File: tb/tb_cc_speed_timer.sv
// Randomized bench for cc_speed_timer against an integer-level model of the tick/level rules.
// Small constants (base 10, step 2, max level 3) keep periods short; comparator is modelled here.
module tb_cc_speed_timer;

  localparam int DW = 23;
  localparam int LW = 2;
  localparam int MAXL = 3;
  localparam int TB_BASE = 10;
  localparam int TB_STEP = 2;

  logic          clk, rst, en, up_n, dn_n, t0_n, boost;
  logic [DW-1:0] data, tc;
  logic [LW-1:0] level;
  logic          tick;

  int n_vec = 0;
  int n_err = 0;

  // Model state
  bit m_run;
  int m_count, m_tc, m_level, m_pend;
  bit m_tick;

  cc_speed_timer #(
    .DATAWIDTH (DW),
    .LEVELWIDTH(LW),
    .MAX_LEVEL (MAXL),
    .TIME_BASE (DW'(TB_BASE)),
    .TIME_STEP (DW'(TB_STEP))
  ) dut (
    .CC_SPEEDTIMER_CLOCK_50       (clk),
    .CC_SPEEDTIMER_RESET_InHigh   (rst),
    .CC_SPEEDTIMER_enable_InHigh  (en),
    .CC_SPEEDTIMER_speedUp_InLow  (up_n),
    .CC_SPEEDTIMER_speedDown_InLow(dn_n),
`ifdef CC_SPEEDTIMER_BOOST_EN
    .CC_SPEEDTIMER_boost_InHigh   (boost),
`endif
    .CC_SPEEDTIMER_T0_InLow       (t0_n),
    .CC_SPEEDTIMER_data_OutBUS    (data),
    .CC_SPEEDTIMER_timeCte_OutBUS (tc),
    .CC_SPEEDTIMER_level_OutBUS   (level),
    .CC_SPEEDTIMER_tick_OutHigh   (tick)
  );

  // Behavioural combinational comparator
  assign t0_n = (data == tc) ? 1'b0 : 1'b1;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int tc_of(input int lvl, input bit b);
    int t;
    t = TB_BASE - lvl * TB_STEP;
`ifdef CC_SPEEDTIMER_BOOST_EN
    if (b) t = t / 2;
`endif
    return t;
  endfunction

  function automatic int req_of(input bit u_n, input bit d_n);
    if (!u_n && d_n) return 1;
    if (u_n && !d_n) return -1;
    return 0;
  endfunction

  task automatic model_reset();
    m_run = 0; m_count = 0; m_tc = TB_BASE; m_level = 0; m_pend = 0; m_tick = 0;
  endtask

  // Advance the model by one rising edge using the inputs present before the edge.
  task automatic model_edge();
    int r;
    r = req_of(up_n, dn_n);
    m_tick = 0;
    if (m_run && en && m_count >= m_tc) begin
      m_level = m_level + m_pend;
      if (m_level > MAXL) m_level = MAXL;
      if (m_level < 0) m_level = 0;
      m_tc    = tc_of(m_level, boost);
      m_count = 0;
      m_tick  = 1;
      m_pend  = r;
    end else begin
      if (r != 0) m_pend = r;
      if (!m_run) begin
        m_count = 0;
        if (en) m_run = 1;
      end else if (en) begin
        m_count++;
      end
    end
  endtask

  task automatic check_all(input string who);
    check_val({who, ".data"},  64'(data),  64'(m_count));
    check_val({who, ".tc"},    64'(tc),    64'(m_tc));
    check_val({who, ".level"}, 64'(level), 64'(m_level));
    check_val({who, ".tick"},  64'(tick),  64'(m_tick));
  endtask

  task automatic run_phase(input int cycles, input int en_pct, input int up_pct,
                           input int dn_pct, input int rst_pct);
    for (int i = 0; i < cycles; i++) begin
      en    = ($urandom_range(0, 99) < en_pct);
      up_n  = !($urandom_range(0, 99) < up_pct);
      dn_n  = !($urandom_range(0, 99) < dn_pct);
      boost = $urandom_range(0, 1) == 1;
      if ($urandom_range(0, 999) < rst_pct) begin
        #1 rst = 1'b1;
        #1;
        model_reset();
        check_all("async_rst");
        rst = 1'b0;
      end
      @(posedge clk);
      model_edge();
      #1;
      check_all("cycle");
    end
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; up_n = 1'b1; dn_n = 1'b1; boost = 1'b0;
    model_reset();
    #2;
    check_all("reset");
    @(posedge clk);
    #1;
    check_all("reset_held");
    rst = 1'b0;

    run_phase(40, 100, 0, 0, 0);       // free run at level 0
    run_phase(150, 100, 12, 0, 0);     // climb to saturation
    run_phase(150, 100, 0, 12, 0);     // descend to floor
    run_phase(30, 0, 10, 10, 0);       // long pause with requests
    run_phase(400, 85, 10, 10, 0);     // mixed, incl. simultaneous up/down
    run_phase(600, 70, 20, 20, 15);    // mixed with async resets

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
